// File: rtl/data_demux_router_if.sv
// Handshake bundle for data_demux_router.
//   Producer side : In, in_valid, sel  -> router ; in_ready <- router
//   Channel 0     : S_0, s0_valid      <- router ; s0_ready -> router
//   Channel 1     : S_1, s1_valid      <- router ; s1_ready -> router
// The slave modport is the router's view; master is the surrounding environment.
interface data_demux_router_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [WIDTH-1:0] In;
  logic             in_valid;
  logic             sel;
  logic             in_ready;
  logic [WIDTH-1:0] S_0;
  logic             s0_valid;
  logic             s0_ready;
  logic [WIDTH-1:0] S_1;
  logic             s1_valid;
  logic             s1_ready;

  modport master (
    output In, in_valid, sel, s0_ready, s1_ready,
    input  in_ready, S_0, s0_valid, S_1, s1_valid
  );

  modport slave (
    input  In, in_valid, sel, s0_ready, s1_ready,
    output in_ready, S_0, s0_valid, S_1, s1_valid
  );
endinterface

// File: rtl/data_demux_router.sv
// Registered 1-to-2 demultiplexer. Each word on bus.In is steered by bus.sel into one of two
// per-channel FIFOs; each channel presents its head word on S_0 / S_1 with its own valid/ready.
// A full channel only blocks words addressed to it.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (flushes both FIFOs, clears outputs)
//   bus   : data_demux_router_if.slave (producer handshake + two consumer channels)
module data_demux_router #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst_n,
  data_demux_router_if.slave bus
);

  localparam logic [PTR_W:0]   CntFull = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [PTR_W-1:0] wptr_q [2];
  logic [PTR_W-1:0] wptr_d [2];
  logic [PTR_W-1:0] rptr_q [2];
  logic [PTR_W-1:0] rptr_d [2];
  logic [PTR_W:0]   cnt_q  [2];
  logic [PTR_W:0]   cnt_d  [2];
  // Registered head word; keeps the last popped value while the channel is empty.
  logic [WIDTH-1:0] head_q [2];
  logic [WIDTH-1:0] head_d [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] push;
  logic [1:0] pop;
  logic       accept;

  always_comb begin
    full  = '0;
    valid = '0;
    for (int c = 0; c < 2; c++) begin
      full[c]  = (cnt_q[c] == CntFull);
      valid[c] = (cnt_q[c] != '0);
    end
  end

  assign ready = {bus.s1_ready, bus.s0_ready};

  // Depends only on sel and registered full flags, never on the consumer ready inputs.
  assign bus.in_ready = rst_n & (bus.sel ? ~full[1] : ~full[0]);

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = {accept & bus.sel, accept & ~bus.sel};
  assign pop    = valid & ready;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      cnt_d[c]  = cnt_q[c];
      head_d[c] = head_q[c];

      if (push[c]) wptr_d[c] = wptr_q[c] + PtrOne;
      if (pop[c])  rptr_d[c] = rptr_q[c] + PtrOne;

      case ({push[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CntOne;
        2'b01:   cnt_d[c] = cnt_q[c] - CntOne;
        default: cnt_d[c] = cnt_q[c];
      endcase

      // Next head is the incoming word when it lands in the slot the read pointer moves to
      // (empty FIFO, or the only entry being popped); otherwise it is already in memory.
      if (cnt_d[c] != '0) begin
        if (push[c] && (rptr_d[c] == wptr_q[c])) begin
          head_d[c] = bus.In;
        end else begin
          head_d[c] = mem_q[c][rptr_d[c]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
        head_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
        head_q[c] <= head_d[c];
      end
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= bus.In;
    end
  end

  assign bus.S_0      = head_q[0];
  assign bus.s0_valid = valid[0];
  assign bus.S_1      = head_q[1];
  assign bus.s1_valid = valid[1];

endmodule

// File: tb/tb_data_demux_router.sv
module tb_data_demux_router;

  localparam int unsigned Width = 16;
  localparam int unsigned Depth = 2;

  logic clk;
  logic rst_n;

  data_demux_router_if #(.WIDTH(Width)) bus ();

  data_demux_router #(
    .WIDTH(Width),
    .DEPTH(Depth),
    .PTR_W(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per channel plus the last value popped from each.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] last0 = 16'h0;
  logic [15:0] last1 = 16'h0;
  int          npop0 = 0;
  int          npop1 = 0;
  int          accepted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, clock, then update the model.
  task automatic cycle(input string tag);
    logic exp_rdy, p0, p1, psh;
    #1;
    exp_rdy = rst_n && !(bus.sel ? (q1.size() == Depth) : (q0.size() == Depth));
    chk({tag, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    chk({tag, ".s0_valid"}, {31'b0, bus.s0_valid}, {31'b0, q0.size() != 0});
    chk({tag, ".s1_valid"}, {31'b0, bus.s1_valid}, {31'b0, q1.size() != 0});
    chk({tag, ".S_0"}, {16'b0, bus.S_0}, {16'b0, (q0.size() != 0) ? q0[0] : last0});
    chk({tag, ".S_1"}, {16'b0, bus.S_1}, {16'b0, (q1.size() != 0) ? q1[0] : last1});
    p0  = (q0.size() != 0) && bus.s0_ready;
    p1  = (q1.size() != 0) && bus.s1_ready;
    psh = bus.in_valid && exp_rdy;
    @(posedge clk);
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      last0 = 16'h0;
      last1 = 16'h0;
    end else begin
      if (p0) begin last0 = q0.pop_front(); npop0++; end
      if (p1) begin last1 = q1.pop_front(); npop1++; end
      if (psh) begin
        accepted++;
        if (bus.sel) q1.push_back(bus.In);
        else         q0.push_back(bus.In);
      end
    end
    #1;
  endtask

  initial begin
    bus.In       = '0;
    bus.in_valid = 1'b0;
    bus.sel      = 1'b0;
    bus.s0_ready = 1'b0;
    bus.s1_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    chk("rst.s0_valid", {31'b0, bus.s0_valid}, 32'd0);
    chk("rst.s1_valid", {31'b0, bus.s1_valid}, 32'd0);
    chk("rst.S_0", {16'b0, bus.S_0}, 32'h0);
    chk("rst.S_1", {16'b0, bus.S_1}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready_after", {31'b0, bus.in_ready}, 32'd1);

    // Single routing
    bus.s0_ready = 1'b1;
    bus.s1_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.sel = 1'b0; bus.In = 16'h00FF;
    cycle("route0");
    chk("route.S_0", {16'b0, bus.S_0}, 32'h00FF);
    chk("route.s0_valid", {31'b0, bus.s0_valid}, 32'd1);
    bus.sel = 1'b1; bus.In = 16'h0000;
    cycle("route1");
    chk("route.s0_pulse", {31'b0, bus.s0_valid}, 32'd0);
    chk("route.S_1", {16'b0, bus.S_1}, 32'h0000);
    chk("route.s1_valid", {31'b0, bus.s1_valid}, 32'd1);
    chk("route.S_0_hold", {16'b0, bus.S_0}, 32'h00FF);
    bus.in_valid = 1'b0;
    cycle("route2");
    chk("route.s1_pulse", {31'b0, bus.s1_valid}, 32'd0);

    // Fill and stall, then full with simultaneous pop
    bus.s0_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.sel = 1'b0; bus.In = 16'h1111;
    cycle("fill1");
    bus.In = 16'h2222;
    cycle("fill2");
    bus.In = 16'h3333;
    #1;
    chk("fill.blocked", {31'b0, bus.in_ready}, 32'd0);
    cycle("fill3");
    chk("fill.held_head", {16'b0, bus.S_0}, 32'h1111);
    bus.sel = 1'b1; bus.In = 16'h4444;
    #1;
    chk("fill.other_ready", {31'b0, bus.in_ready}, 32'd1);
    cycle("fill_s1");
    chk("fill.S_1", {16'b0, bus.S_1}, 32'h4444);
    bus.sel = 1'b0; bus.In = 16'h3333;
    bus.s0_ready = 1'b1;
    #1;
    chk("fullpop.no_push", {31'b0, bus.in_ready}, 32'd0);
    cycle("fullpop1");
    chk("fullpop.S_0", {16'b0, bus.S_0}, 32'h2222);
    chk("fullpop.ready_next", {31'b0, bus.in_ready}, 32'd1);
    cycle("fullpop2");
    chk("fullpop.S_0_3333", {16'b0, bus.S_0}, 32'h3333);
    bus.in_valid = 1'b0;
    cycle("fullpop3");
    chk("fullpop.empty", {31'b0, bus.s0_valid}, 32'd0);

    // Streaming across pointer wrap
    bus.in_valid = 1'b1;
    bus.sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.In = 16'(i);
      cycle("stream");
    end
    bus.in_valid = 1'b0;
    cycle("stream_end");
    chk("stream.last", {16'b0, bus.S_0}, 32'd19);

    // Interleaved traffic with random back-pressure
    accepted = 0;
    npop0 = 0;
    npop1 = 0;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 3000 && accepted < 200; cyc++) begin
      bus.sel = cyc[0];
      bus.In = {cyc[0], 15'(accepted)};
      bus.s0_ready = 1'($urandom_range(0, 1));
      bus.s1_ready = 1'($urandom_range(0, 1));
      cycle("ilv");
    end
    chk("ilv.accepted", accepted, 32'd200);
    bus.in_valid = 1'b0;
    bus.s0_ready = 1'b1;
    bus.s1_ready = 1'b1;
    repeat (4) cycle("ilv_drain");
    chk("ilv.total_out", npop0 + npop1, 32'd200);

    // Reset mid-operation with both channels holding two words
    bus.s0_ready = 1'b0;
    bus.s1_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.sel = 1'b0; bus.In = 16'hA000; cycle("rfill");
    bus.sel = 1'b1; bus.In = 16'hB000; cycle("rfill");
    bus.sel = 1'b0; bus.In = 16'hA001; cycle("rfill");
    bus.sel = 1'b1; bus.In = 16'hB001; cycle("rfill");
    chk("rmid.s0_full", {31'b0, bus.s0_valid}, 32'd1);
    rst_n = 1'b0;
    bus.sel = 1'b0; bus.In = 16'hDEAD;
    #1;
    chk("rmid.in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    cycle("rmid");
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rmid.s0_valid", {31'b0, bus.s0_valid}, 32'd0);
    chk("rmid.s1_valid", {31'b0, bus.s1_valid}, 32'd0);
    chk("rmid.S_0", {16'b0, bus.S_0}, 32'h0);
    chk("rmid.S_1", {16'b0, bus.S_1}, 32'h0);
    chk("rmid.in_ready_high", {31'b0, bus.in_ready}, 32'd1);
    bus.s0_ready = 1'b1;
    bus.s1_ready = 1'b1;
    repeat (3) cycle("rpost");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
